// File: rtl/seq_pkg.sv
// Shared types and default widths for the sequence step tracker.
package seq_pkg;

  localparam int unsigned DEF_PTR_W  = 64;
  localparam int unsigned DEF_STEP_W = 32;
  localparam int unsigned DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_boundary_cmp.sv
// Overflow-safe pointer-vs-boundary compares: step complete, and a full step behind.
module seq_boundary_cmp #(
  parameter int unsigned PTR_W  = 64,
  parameter int unsigned STEP_W = 32
) (
  input  logic [PTR_W-1:0]  writepointer,
  input  logic [PTR_W-1:0]  end_of_step,
  input  logic [STEP_W-1:0] step_size,
  output logic              at_end_c,
  output logic              lag_c
);

  localparam int unsigned EXT_W = PTR_W + 1;

  logic [EXT_W-1:0] wp_ext;
  logic [EXT_W-1:0] end_ext;
  logic [EXT_W-1:0] next_end_ext;

  // One extra bit keeps end_of_step + step_size from wrapping below the pointer.
  assign wp_ext       = EXT_W'(writepointer);
  assign end_ext      = EXT_W'(end_of_step);
  assign next_end_ext = end_ext + EXT_W'(step_size);

  assign at_end_c = (wp_ext >= end_ext);
  assign lag_c    = (wp_ext >= next_end_ext);

endmodule

// File: rtl/sequence_step_tracker.sv
// Tracks write-pointer progress through a stepped, optionally wrapping and repeating sequence.
module sequence_step_tracker
  import seq_pkg::*;
#(
  parameter int unsigned PTR_W  = DEF_PTR_W,
  parameter int unsigned STEP_W = DEF_STEP_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [PTR_W-1:0]  writepointer,
  input  logic [PTR_W-1:0]  start_ptr,
  input  logic [STEP_W-1:0] step_size,
  input  logic [CNT_W-1:0]  num_steps,
  input  logic [CNT_W-1:0]  num_reps,
  output logic [CNT_W-1:0]  step_counter,
  output logic [CNT_W-1:0]  step_index,
  output logic [CNT_W-1:0]  rep_counter,
  output logic              step_pulse,
  output logic              lagging,
  output logic              running,
  output logic              done,
  output logic              cfg_error
);

  seq_state_e        state_q, state_n;
  logic              en_q;
  logic              rise_c;
  logic [PTR_W-1:0]  end_q, end_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic [CNT_W-1:0]  nsteps_q, nsteps_n;
  logic [CNT_W-1:0]  nreps_q, nreps_n;
  logic [CNT_W-1:0]  cnt_n, idx_n, rep_n;
  logic              pulse_n, lag_n;
  logic              at_end_c, lag_c;

  assign rise_c = enable & ~en_q;

  seq_boundary_cmp #(
    .PTR_W  (PTR_W),
    .STEP_W (STEP_W)
  ) u_cmp (
    .writepointer (writepointer),
    .end_of_step  (end_q),
    .step_size    (step_q),
    .at_end_c     (at_end_c),
    .lag_c        (lag_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state_q;
    end_n    = end_q;
    step_n   = step_q;
    nsteps_n = nsteps_q;
    nreps_n  = nreps_q;
    cnt_n    = step_counter;
    idx_n    = step_index;
    rep_n    = rep_counter;
    pulse_n  = 1'b0;
    lag_n    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise_c) begin
          if (step_size == '0) begin
            state_n = ERROR;
          end else begin
            state_n  = RUN;
            step_n   = step_size;
            nsteps_n = num_steps;
            nreps_n  = num_reps;
            end_n    = start_ptr + PTR_W'(step_size);
            cnt_n    = '0;
            idx_n    = '0;
            rep_n    = '0;
          end
        end
      end
      RUN: begin
        // Dropping enable discards any advance seen in the same cycle.
        if (!enable) begin
          state_n = IDLE;
        end else if (at_end_c) begin
          end_n   = end_q + PTR_W'(step_q);
          cnt_n   = step_counter + CNT_W'(1);
          pulse_n = 1'b1;
          lag_n   = lag_c;
          if ((nsteps_q != '0) && (step_index == nsteps_q - CNT_W'(1))) begin
            idx_n = '0;
            rep_n = rep_counter + CNT_W'(1);
            if ((nreps_q != '0) && (rep_n == nreps_q)) begin
              state_n = DONE;
            end
          end else begin
            idx_n = step_index + CNT_W'(1);
          end
        end
      end
      DONE, ERROR: begin
        if (!enable) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, latched config and registered outputs.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      // Capture the current level so an enable held through reset is not an edge.
      en_q         <= enable;
      end_q        <= '0;
      step_q       <= '0;
      nsteps_q     <= '0;
      nreps_q      <= '0;
      step_counter <= '0;
      step_index   <= '0;
      rep_counter  <= '0;
      step_pulse   <= 1'b0;
      lagging      <= 1'b0;
      running      <= 1'b0;
      done         <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      state_q      <= state_n;
      en_q         <= enable;
      end_q        <= end_n;
      step_q       <= step_n;
      nsteps_q     <= nsteps_n;
      nreps_q      <= nreps_n;
      step_counter <= cnt_n;
      step_index   <= idx_n;
      rep_counter  <= rep_n;
      step_pulse   <= pulse_n;
      lagging      <= lag_n;
      running      <= (state_n == RUN);
      done         <= (state_n == DONE);
      cfg_error    <= (state_n == ERROR);
    end
  end

endmodule

// File: tb/tb_sequence_step_tracker.sv
// Directed, table-driven bench for sequence_step_tracker.
module tb_sequence_step_tracker;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [63:0] writepointer;
  logic [63:0] start_ptr;
  logic [31:0] step_size;
  logic [31:0] num_steps;
  logic [31:0] num_reps;
  logic [31:0] step_counter;
  logic [31:0] step_index;
  logic [31:0] rep_counter;
  logic        step_pulse;
  logic        lagging;
  logic        running;
  logic        done;
  logic        cfg_error;

  int checks = 0;
  int errors = 0;

  sequence_step_tracker dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .enable       (enable),
    .writepointer (writepointer),
    .start_ptr    (start_ptr),
    .step_size    (step_size),
    .num_steps    (num_steps),
    .num_reps     (num_reps),
    .step_counter (step_counter),
    .step_index   (step_index),
    .rep_counter  (rep_counter),
    .step_pulse   (step_pulse),
    .lagging      (lagging),
    .running      (running),
    .done         (done),
    .cfg_error    (cfg_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [63:0] wp;
    logic [31:0] cnt;
    logic [31:0] idx;
    logic [31:0] rep;
    logic        pulse;
    logic        lag;
    logic        run;
    logic        dn;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] cnt, input logic [31:0] idx,
                           input logic [31:0] rep, input logic pulse, input logic lag,
                           input logic run, input logic dn, input logic err);
    check({tag, " step_counter"}, 64'(step_counter), 64'(cnt));
    check({tag, " step_index"},   64'(step_index),   64'(idx));
    check({tag, " rep_counter"},  64'(rep_counter),  64'(rep));
    check({tag, " step_pulse"},   64'(step_pulse),   64'(pulse));
    check({tag, " lagging"},      64'(lagging),      64'(lag));
    check({tag, " running"},      64'(running),      64'(run));
    check({tag, " done"},         64'(done),         64'(dn));
    check({tag, " cfg_error"},    64'(cfg_error),    64'(err));
  endtask

  initial begin
    //            en  wp    cnt idx rep pls lag run dn
    vecs[0]  = '{1'b1, 64'd0,   32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // held through reset: no arm
    vecs[1]  = '{1'b0, 64'd0,   32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 64'd0,   32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0}; // arm
    vecs[3]  = '{1'b1, 64'd99,  32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 64'd100, 32'd1, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 64'd100, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 64'd100, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // counters hold in IDLE
    vecs[7]  = '{1'b1, 64'd0,   32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0}; // re-arm clears
    vecs[8]  = '{1'b1, 64'd350, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 64'd350, 32'd2, 32'd2, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 64'd350, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 64'd350, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 64'd399, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 64'd400, 32'd4, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};

    aresetn = 1'b0; enable = 1'b1; writepointer = '0;
    start_ptr = 64'd0; step_size = 32'd100; num_steps = 32'd0; num_reps = 32'd0;
    tick(); tick();
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    aresetn = 1'b1;

    // Basic stepping and multi-step catch-up
    for (int i = 0; i < 14; i++) begin
      enable = vecs[i].en;
      writepointer = vecs[i].wp;
      tick();
      check_all($sformatf("row%0d", i), vecs[i].cnt, vecs[i].idx, vecs[i].rep,
                vecs[i].pulse, vecs[i].lag, vecs[i].run, vecs[i].dn, 1'b0);
    end

    // Sequence wrap with finite repetitions
    enable = 1'b0; tick();
    check_all("disarm", 4, 4, 0, 0, 0, 0, 0, 0);
    step_size = 32'd10; num_steps = 32'd4; num_reps = 32'd2; writepointer = 64'd0;
    enable = 1'b1; tick();
    check_all("wrap arm", 0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      writepointer = 64'(10 * k);
      tick();
      if (k <= 8)
        check_all($sformatf("wrap k%0d", k), 32'(k), 32'(k % 4), 32'(k / 4), 1'b1, 1'b0,
                  (k < 8), (k == 8), 1'b0);
      else
        check_all($sformatf("wrap k%0d", k), 8, 0, 2, 0, 0, 0, 1, 0);
    end
    enable = 1'b0; tick();
    check_all("done drop", 8, 0, 2, 0, 0, 0, 0, 0);

    // Zero step size is a config error
    step_size = 32'd0; num_steps = 32'd0; num_reps = 32'd0; writepointer = 64'd0;
    enable = 1'b1; tick();
    check("err flag", 64'(cfg_error), 64'd1);
    check("err running", 64'(running), 64'd0);
    for (int i = 0; i < 2; i++) begin
      writepointer = 64'd500;
      tick();
      check($sformatf("err pulse%0d", i), 64'(step_pulse), 64'd0);
      check($sformatf("err hold%0d", i), 64'(cfg_error), 64'd1);
    end
    enable = 1'b0; tick();
    check("err clear", 64'(cfg_error), 64'd0);

    // Start offset ahead of the pointer; config changes while running are ignored
    start_ptr = 64'd1000; step_size = 32'd50; writepointer = 64'd0;
    enable = 1'b1; tick();
    check_all("ofs arm", 0, 0, 0, 0, 0, 1, 0, 0);
    start_ptr = 64'd0; step_size = 32'd7;
    writepointer = 64'd1000; tick();
    check_all("ofs 1000", 0, 0, 0, 0, 0, 1, 0, 0);
    writepointer = 64'd1049; tick();
    check_all("ofs 1049", 0, 0, 0, 0, 0, 1, 0, 0);
    writepointer = 64'd1050; tick();
    check_all("ofs 1050", 1, 1, 0, 1, 0, 1, 0, 0);
    enable = 1'b0; tick();

    // Enable falling on the crossing cycle discards the advance
    start_ptr = 64'd0; step_size = 32'd100; writepointer = 64'd0;
    enable = 1'b1; tick();
    writepointer = 64'd50; tick();
    check_all("race pre", 0, 0, 0, 0, 0, 1, 0, 0);
    enable = 1'b0; writepointer = 64'd100; tick();
    check_all("race drop", 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of RUN
    enable = 1'b1; tick();
    check_all("rst arm", 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    check_all("rst step1", 1, 1, 0, 1, 0, 1, 0, 0);
    writepointer = 64'd200; tick();
    check_all("rst step2", 2, 2, 0, 1, 0, 1, 0, 0);
    aresetn = 1'b0; tick();
    check_all("rst mid", 0, 0, 0, 0, 0, 0, 0, 0);
    aresetn = 1'b1; tick();
    check_all("rst release", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
